// File: rtl/vector_dnsize.sv
// vector_dnsize: splits one IN_W-bit word into RATIO = IN_W/OUT_W OUT_W-bit
// beats, valid/ready on both sides, with beat framing (out_first/out_last).
// Optional feature macro: VEC_DNSIZE_PARITY_EN adds out_par (even parity of out_data).
module vector_dnsize #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_first,
  output logic             out_last
`ifdef VEC_DNSIZE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] hold, hold_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   sel;
  logic [OUT_W-1:0] beat;
  logic            in_fire, out_fire;

  assign out_valid = (state == SEND);
  assign out_first = out_valid & (cnt == '0);
  assign out_last  = out_valid & (cnt == LAST);
  // Ready early when the final beat is leaving, giving zero-bubble streaming.
  assign in_ready  = !out_valid | (out_ready & out_last);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state, beat counter and holding register update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    if (in_fire) begin
      hold_nxt  = in_data;
      cnt_nxt   = '0;
      state_nxt = SEND;
    end else if (out_fire) begin
      if (out_last) begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State register; reset discards any partially sent word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
    end
  end

  // Beat selection from registered state only; output forced to 0 when idle.
  always_comb begin
    sel = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;
    beat = hold[int'(sel) * OUT_W +: OUT_W];
    out_data = out_valid ? beat : '0;
  end

`ifdef VEC_DNSIZE_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_vector_dnsize.sv
// Directed bench for vector_dnsize: three instances (16/8 LSB-first,
// 16/8 MSB-first, 32/8 LSB-first) sharing clock and reset.
module tb_vector_dnsize;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: 16 -> 8, LSB first
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic a_out_first, a_out_last, a_out_par;
  logic [15:0] a_in_data = '0;
  logic [7:0]  a_out_data;
  // Instance B: 16 -> 8, MSB first
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic b_out_first, b_out_last, b_out_par;
  logic [15:0] b_in_data = '0;
  logic [7:0]  b_out_data;
  // Instance C: 32 -> 8, LSB first
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
  logic c_out_first, c_out_last, c_out_par;
  logic [31:0] c_in_data = '0;
  logic [7:0]  c_out_data;

  vector_dnsize #(.IN_W(16), .OUT_W(8), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_first(a_out_first), .out_last(a_out_last)
`ifdef VEC_DNSIZE_PARITY_EN
    , .out_par(a_out_par)
`endif
  );

  vector_dnsize #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last)
`ifdef VEC_DNSIZE_PARITY_EN
    , .out_par(b_out_par)
`endif
  );

  vector_dnsize #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_first(c_out_first), .out_last(c_out_last)
`ifdef VEC_DNSIZE_PARITY_EN
    , .out_par(c_out_par)
`endif
  );

`ifndef VEC_DNSIZE_PARITY_EN
  assign a_out_par = 1'b0;
  assign b_out_par = 1'b0;
  assign c_out_par = 1'b0;
`endif

  // Observation tuple: {out_valid, out_first, out_last, in_ready, out_data}
  logic [11:0] obs, exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    obs = {a_out_valid, a_out_first, a_out_last, a_in_ready, a_out_data};
    exp = {4'b0001, 8'h00};
    if (obs !== exp) begin $display("FAIL reset_a got=%h exp=%h", obs, exp); failures++; end
    checks++;
    obs = {c_out_valid, c_out_first, c_out_last, c_in_ready, c_out_data};
    if (obs !== exp) begin $display("FAIL reset_c got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    a_out_ready = 1; a_in_valid = 1; a_in_data = 16'hA55A;
    #1;
    if (a_in_ready !== 1'b1) begin $display("FAIL basic_ready_idle got=%b exp=1", a_in_ready); failures++; end
    checks++;
    step();
    a_in_valid = 0;
    #1;
    obs = {a_out_valid, a_out_first, a_out_last, a_in_ready, a_out_data};
    exp = {4'b1100, 8'h5A};
    if (obs !== exp) begin $display("FAIL basic_beat0 got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    obs = {a_out_valid, a_out_first, a_out_last, a_in_ready, a_out_data};
    exp = {4'b1011, 8'hA5};
    if (obs !== exp) begin $display("FAIL basic_beat1 got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    obs = {a_out_valid, a_out_first, a_out_last, a_in_ready, a_out_data};
    exp = {4'b0001, 8'h00};
    if (obs !== exp) begin $display("FAIL basic_idle got=%h exp=%h", obs, exp); failures++; end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [7:0]  beats [6];
    words = '{16'h1234, 16'h5678, 16'h9ABC};
    beats = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    a_out_ready = 1; a_in_valid = 1; a_in_data = words[0];
    step();
    for (int i = 0; i < 6; i++) begin
      if (i / 2 + 1 < 3) begin
        a_in_valid = 1; a_in_data = words[i / 2 + 1];
      end else begin
        a_in_valid = 0; a_in_data = 16'hFFFF;
      end
      #1;
      obs = {a_out_valid, a_out_first, a_out_last, a_in_ready, a_out_data};
      exp = {1'b1, (i % 2 == 0), (i % 2 == 1), (i % 2 == 1), beats[i]};
      if (obs !== exp) begin $display("FAIL stream_beat%0d got=%h exp=%h", i, obs, exp); failures++; end
      checks++;
      step();
    end
    if (a_out_valid !== 1'b0) begin $display("FAIL stream_end got=%b exp=0", a_out_valid); failures++; end
    checks++;
  endtask

  task automatic test_backpressure();
    b_out_ready = 1; b_in_valid = 1; b_in_data = 16'hBEEF;
    step();
    b_out_ready = 0; b_in_data = 16'h1111;  // must be ignored while mid-word
    for (int i = 0; i < 3; i++) begin
      #1;
      obs = {b_out_valid, b_out_first, b_out_last, b_in_ready, b_out_data};
      exp = {4'b1100, 8'hBE};
      if (obs !== exp) begin $display("FAIL bp_stall%0d got=%h exp=%h", i, obs, exp); failures++; end
      checks++;
      step();
    end
    b_out_ready = 1; b_in_valid = 0;
    #1;
    obs = {b_out_valid, b_out_first, b_out_last, b_in_ready, b_out_data};
    exp = {4'b1100, 8'hBE};
    if (obs !== exp) begin $display("FAIL bp_release got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    obs = {b_out_valid, b_out_first, b_out_last, b_in_ready, b_out_data};
    exp = {4'b1011, 8'hEF};
    if (obs !== exp) begin $display("FAIL bp_beat1 got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    if (b_out_valid !== 1'b0) begin $display("FAIL bp_idle got=%b exp=0", b_out_valid); failures++; end
    checks++;
  endtask

  task automatic test_wide_ratio();
    logic [31:0] w [2];
    logic [7:0]  e [8];
    w = '{32'h11223344, 32'h55667788};
    e = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    c_out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      c_in_valid = 1; c_in_data = w[k];
      step();
      c_in_valid = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        obs = {c_out_valid, c_out_first, c_out_last, c_in_ready, c_out_data};
        exp = {1'b1, (i == 0), (i == 3), (i == 3), e[k * 4 + i]};
        if (obs !== exp) begin $display("FAIL wide_w%0d_b%0d got=%h exp=%h", k, i, obs, exp); failures++; end
        checks++;
        step();
      end
      obs = {c_out_valid, c_out_first, c_out_last, c_in_ready, c_out_data};
      exp = {4'b0001, 8'h00};
      if (obs !== exp) begin $display("FAIL wide_idle%0d got=%h exp=%h", k, obs, exp); failures++; end
      checks++;
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] e [4];
    e = '{8'h04, 8'h03, 8'h02, 8'h01};
    c_out_ready = 1; c_in_valid = 1; c_in_data = 32'hDEADBEEF;
    step();
    c_in_valid = 0;
    step();  // now presenting beat 1 (0xBE)
    if (c_out_data !== 8'hBE) begin $display("FAIL rst_pre got=%h exp=be", c_out_data); failures++; end
    checks++;
    #1;
    rst_n = 1'b0;
    #1;
    obs = {c_out_valid, c_out_first, c_out_last, c_in_ready, c_out_data};
    exp = {4'b0001, 8'h00};
    if (obs !== exp) begin $display("FAIL rst_async got=%h exp=%h", obs, exp); failures++; end
    checks++;
    step();
    rst_n = 1'b1;
    step();
    c_in_valid = 1; c_in_data = 32'h01020304;
    step();
    c_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      obs = {c_out_valid, c_out_first, c_out_last, c_in_ready, c_out_data};
      exp = {1'b1, (i == 0), (i == 3), (i == 3), e[i]};
      if (obs !== exp) begin $display("FAIL rst_after_b%0d got=%h exp=%h", i, obs, exp); failures++; end
      checks++;
      step();
    end
    if (c_out_valid !== 1'b0) begin $display("FAIL rst_after_idle got=%b exp=0", c_out_valid); failures++; end
    checks++;
  endtask

`ifdef VEC_DNSIZE_PARITY_EN
  task automatic test_parity();
    if (a_out_par !== 1'b0) begin $display("FAIL par_idle got=%b exp=0", a_out_par); failures++; end
    checks++;
    a_out_ready = 1; a_in_valid = 1; a_in_data = 16'h0701;
    step();
    a_in_valid = 0;
    #1;
    if ({a_out_data, a_out_par} !== {8'h01, 1'b1}) begin
      $display("FAIL par_beat0 got=%h/%b exp=01/1", a_out_data, a_out_par); failures++;
    end
    checks++;
    step();
    if ({a_out_data, a_out_par} !== {8'h07, 1'b1}) begin
      $display("FAIL par_beat1 got=%h/%b exp=07/1", a_out_data, a_out_par); failures++;
    end
    checks++;
    step();
    if (a_out_par !== 1'b0) begin $display("FAIL par_end got=%b exp=0", a_out_par); failures++; end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wide_ratio();
    test_reset_midword();
`ifdef VEC_DNSIZE_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
